// File: rtl/pulse_burst_pkg.sv
// ============================================================================
//  Module   : pulse_burst_pkg
//  Purpose  : Shared state encoding and default widths for the pulse burst
//             generator.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pulse_burst_pkg;

    localparam int c_DEFAULT_COUNT_W  = 4;
    localparam int c_DEFAULT_PERIOD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } burst_state_t;

endpackage

`default_nettype wire

// File: rtl/pulse_period_div.sv
// ============================================================================
//  Module   : pulse_period_div
//  Purpose  : Reloadable down-counter that flags when it reaches zero. It
//             holds at zero instead of wrapping.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_period_div
    import pulse_burst_pkg::*;
#(
    parameter int PERIOD_W = c_DEFAULT_PERIOD_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [PERIOD_W-1:0] load_val,
    input  logic                en,
    output logic                zero
);

    logic [PERIOD_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en && !zero) begin
            r_cnt <= r_cnt - PERIOD_W'(1);
        end
    end

    assign zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/pulse_burst_gen.sv
// ============================================================================
//  Module   : pulse_burst_gen
//  Purpose  : Emits N single-cycle pulses spaced P+1 clocks apart, then a
//             one-cycle done strobe. Define PULSE_BURST_ABORT_EN to add abort.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_burst_gen
    import pulse_burst_pkg::*;
#(
    parameter int COUNT_W  = c_DEFAULT_COUNT_W,
    parameter int PERIOD_W = c_DEFAULT_PERIOD_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [COUNT_W-1:0]  count,
    input  logic [PERIOD_W-1:0] period,
    output logic                out_pulse,
    output logic [COUNT_W-1:0]  remaining,
    output logic                busy,
    output logic                done
`ifdef PULSE_BURST_ABORT_EN
    ,
    input  logic                abort
`endif
);

    burst_state_t        r_state;
    burst_state_t        w_state_nxt;
    logic [COUNT_W-1:0]  r_rem;
    logic [COUNT_W-1:0]  w_rem_nxt;
    logic [PERIOD_W-1:0] r_period;
    logic                w_accept;
    logic                w_reload;
    logic                w_pulse;
    logic                w_zero;
    logic                w_abort;

`ifdef PULSE_BURST_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // Reload from the live input on accept, since r_period is not yet valid.
    pulse_period_div #(
        .PERIOD_W (PERIOD_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (w_accept | w_reload),
        .load_val (w_accept ? period : r_period),
        .en       (r_state == ST_RUN),
        .zero     (w_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rem    <= '0;
            r_period <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            if (w_accept) begin
                r_period <= period;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_accept    = 1'b0;
        w_reload    = 1'b0;
        w_pulse     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        w_accept    = 1'b1;
                        w_rem_nxt   = count;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_zero) begin
                    w_pulse  = 1'b1;
                    w_reload = 1'b1;
                    if (r_rem != '0) begin
                        w_rem_nxt = r_rem - COUNT_W'(1);
                    end
                    if (r_rem <= COUNT_W'(1)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign out_pulse = w_pulse;
    assign remaining = (r_state == ST_RUN) ? r_rem : '0;
    assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign done      = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_pulse_burst_gen.sv
// ============================================================================
//  Module   : tb_pulse_burst_gen
//  Purpose  : Directed self-checking bench for pulse_burst_gen.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pulse_burst_gen;

    localparam int COUNT_W  = 4;
    localparam int PERIOD_W = 8;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [COUNT_W-1:0]  count = '0;
    logic [PERIOD_W-1:0] period = '0;
    logic                out_pulse;
    logic [COUNT_W-1:0]  remaining;
    logic                busy;
    logic                done;
`ifdef PULSE_BURST_ABORT_EN
    logic                abort = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pulse_burst_gen #(
        .COUNT_W  (COUNT_W),
        .PERIOD_W (PERIOD_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .count     (count),
        .period    (period),
        .out_pulse (out_pulse),
        .remaining (remaining),
        .busy      (busy),
        .done      (done)
`ifdef PULSE_BURST_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    // Presents a request for one edge; returns at the sample point of cycle 1.
    task automatic issue(input int n, input int p);
        @(negedge clk);
        start  = 1'b1;
        count  = COUNT_W'(n);
        period = PERIOD_W'(p);
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_tests++;
        if ({out_pulse, busy, done, remaining} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %b expected 0", {out_pulse, busy, done, remaining});
        end
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_tests++;
            if ({out_pulse, busy, done, remaining} !== 7'd0) begin
                n_fail++;
                $display("FAIL idle_c%0d: got %b expected 0", c, {out_pulse, busy, done, remaining});
            end
        end
    endtask

    // Generic burst check against the cycle-index timing model.
    task automatic test_burst(input int n, input int p, input int ncyc);
        int last;
        int e_pulse, e_done, e_busy, e_rem;
        last = n * (p + 1);
        issue(n, p);
        for (int c = 1; c <= ncyc; c++) begin
            if (c > 1) @(negedge clk);
            e_pulse = ((c % (p + 1)) == 0 && c <= last) ? 1 : 0;
            e_done  = (c == last + 1) ? 1 : 0;
            e_busy  = (c <= last + 1) ? 1 : 0;
            e_rem   = (c <= last) ? n - (c - 1) / (p + 1) : 0;
            n_tests++;
            if (out_pulse !== e_pulse[0] || done !== e_done[0] || busy !== e_busy[0] ||
                remaining !== e_rem[COUNT_W-1:0]) begin
                n_fail++;
                $display("FAIL burst_n%0d_p%0d_c%0d: got pulse=%b done=%b busy=%b rem=%0d expected pulse=%0d done=%0d busy=%0d rem=%0d",
                         n, p, c, out_pulse, done, busy, remaining, e_pulse, e_done, e_busy, e_rem);
            end
        end
    endtask

    task automatic test_terminal_counter;
        int step;
        int wraps;
        step  = 0;
        wraps = 0;
        issue(4, 0);
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            if (out_pulse) begin
                if (step == 3) begin
                    wraps++;
                    step = 0;
                end else begin
                    step++;
                end
            end
        end
        n_tests++;
        if (wraps !== 1 || step !== 0) begin
            n_fail++;
            $display("FAIL tc_wrap: got wraps=%0d step=%0d expected wraps=1 step=0", wraps, step);
        end
    endtask

    task automatic test_ignore_restart;
        int e_pulse;
        issue(2, 1);
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 2) begin
                start  = 1'b1;
                count  = 4'd9;
                period = 8'd0;
            end
            if (c == 3) start = 1'b0;
            e_pulse = (c == 2 || c == 4) ? 1 : 0;
            n_tests++;
            if (out_pulse !== e_pulse[0] || done !== (c == 5) || busy !== (c <= 5)) begin
                n_fail++;
                $display("FAIL restart_c%0d: got pulse=%b done=%b busy=%b expected pulse=%0d done=%0d busy=%0d",
                         c, out_pulse, done, busy, e_pulse, (c == 5), (c <= 5));
            end
        end
    endtask

    task automatic test_held_start;
        issue(1, 0);
        start = 1'b1;
        n_tests++;
        if (out_pulse !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL held_c1: got pulse=%b busy=%b expected 1 1", out_pulse, busy);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL held_c2: got done=%b expected 1", done);
        end
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || out_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL held_c3: got busy=%b pulse=%b expected 0 0", busy, out_pulse);
        end
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (out_pulse !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL held_c4: got pulse=%b busy=%b expected 1 1", out_pulse, busy);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_end: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid;
        int seen_done;
        seen_done = 0;
        issue(3, 2);
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (out_pulse !== 1'b1 || remaining !== 4'd3) begin
            n_fail++;
            $display("FAIL rmid_c3: got pulse=%b rem=%0d expected 1 3", out_pulse, remaining);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({out_pulse, busy, done, remaining} !== 7'd0) begin
            n_fail++;
            $display("FAIL rmid_async: got %b expected 0", {out_pulse, busy, done, remaining});
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy || out_pulse) seen_done = 1;
        end
        n_tests++;
        if (seen_done !== 0) begin
            n_fail++;
            $display("FAIL rmid_after: got activity=%0d expected 0", seen_done);
        end
    endtask

    task automatic test_max_burst;
        int pulses;
        int done_cyc;
        pulses   = 0;
        done_cyc = 0;
        issue(15, 255);
        for (int c = 1; c <= 3900; c++) begin
            if (c > 1) @(negedge clk);
            if (out_pulse) pulses++;
            if (done && done_cyc == 0) done_cyc = c;
        end
        n_tests++;
        if (pulses !== 15 || done_cyc !== 3841) begin
            n_fail++;
            $display("FAIL max_burst: got pulses=%0d done_cycle=%0d expected 15 3841", pulses, done_cyc);
        end
    endtask

`ifdef PULSE_BURST_ABORT_EN
    task automatic test_abort;
        int pulses;
        pulses = 0;
        issue(5, 1);
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin
                if (c == 4) begin
                    @(posedge clk);
                    #1 abort = 1'b1;
                end
                if (c == 5) begin
                    @(posedge clk);
                    #1 abort = 1'b0;
                end
                @(negedge clk);
            end
            if (out_pulse) pulses++;
            if (c == 4) begin
                n_tests++;
                if (out_pulse !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_c4: got pulse=%b expected 0", out_pulse);
                end
            end
            if (c >= 5) begin
                n_tests++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_c%0d: got busy=%b done=%b expected 0 0", c, busy, done);
                end
            end
        end
        n_tests++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL abort_pulses: got %0d expected 1", pulses);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_burst(3, 2, 12);
        test_burst(0, 5, 3);
        test_burst(4, 0, 7);
        test_terminal_counter();
        test_ignore_restart();
        test_held_start();
        test_reset_mid();
        test_max_burst();
`ifdef PULSE_BURST_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pulse_burst_gen.md
# pulse_burst_gen

Programmable pulse-train source that drives the pulse input of the design's terminal-count counters. A request loads a pulse count N and a spacing P. The block then emits exactly N single-cycle pulses, spaced P+1 clocks apart, and signals completion with a one-cycle `done`. It sits between game/control logic and the counter chain, so that counters see a known number of increments.

## Interface
Parameters:
- `COUNT_W`, default 4: width of pulse count and `remaining`.
- `PERIOD_W`, default 8: width of spacing value P.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request. Sampled only in IDLE; ignored while `busy`.
- `count`  in  COUNT_W  number of pulses N, unsigned. Latched on accepted `start`.
- `period`  in  PERIOD_W  spacing P, unsigned. Latched on accepted `start`.
- `out_pulse`  out  1  one-cycle pulse, high only in RUN.
- `remaining`  out  COUNT_W  pulses still to emit, counting the current one.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle completion strobe, high only in DONE.
- `abort`  in  1  present only with `PULSE_BURST_ABORT_EN` (see Configuration).

## Operation
States:
- IDLE:
  - `start`=1 and `count`≠0: latch N and P; divider←P; rem←N; go to RUN.
  - `start`=1 and `count`=0: go to DONE (zero pulses emitted).
  - Otherwise: stay in IDLE.
- RUN:
  - Divider decrements each cycle.
  - When divider=0, `out_pulse`=1 this cycle (combinational from state and divider). At that edge: divider←P and rem←rem−1.
  - If rem=1 at that edge, go to DONE.
- DONE: `done`=1 for exactly one cycle, then unconditional return to IDLE.

Arithmetic and boundaries:
- Divider is PERIOD_W bits; rem is COUNT_W bits. Neither ever wraps: rem is never decremented at 0, and the divider reloads at 0.
- `remaining` = rem in RUN; 0 in IDLE and DONE.
- P=0: pulses every cycle, `out_pulse` high continuously for N cycles.
- P=2^PERIOD_W−1 and N=2^COUNT_W−1 (maximum burst) must complete with no overflow.
- `start` held high through completion starts a new burst on the first IDLE cycle; no request is queued while `busy`.
- Changes on `count`/`period` during a burst have no effect.
- `reset` asserted mid-burst: immediate return to IDLE, all outputs 0, no `done`.

## Timing
- Reset values: state=IDLE; `out_pulse`, `busy`, `done` = 0; `remaining`=0; divider and rem = 0.
- Cycle 1 is the cycle after the edge that accepts `start`. Pulse i (i=1..N) is high in cycle i·(P+1).
- `done` is high in cycle N·(P+1)+1.
- `busy` is high in cycles 1 through N·(P+1)+1.
- The next `start` can be accepted at the edge ending cycle N·(P+1)+2.
- N=0: `done` in cycle 1, `busy` in cycle 1 only, no pulse.

## Configuration
- `PULSE_BURST_ABORT_EN` defined:
  - Adds the `abort` input.
  - `abort`=1 in RUN: `out_pulse` is forced to 0 that cycle, and the next state is IDLE. `done` is not asserted.
  - `abort` is ignored in IDLE and DONE.
- Not defined: `abort` port absent; every accepted burst runs to completion.

## Structure
- Shared package `pulse_burst_pkg`:
  - state enum typedef (IDLE, RUN, DONE)
  - default `COUNT_W`/`PERIOD_W` constants
- Sub-module `pulse_period_div`:
  - reloadable down-counter
  - ports: `clk`, `reset`, `load`, `load_val`, `en`
  - output: `zero`
- Top level holds the FSM, rem counter, and output decode.

## Test plan
- Reset then idle: no `start` for 20 cycles → `out_pulse`, `busy`, `done`, `remaining` all 0.
- N=3, P=2 → pulses in cycles 3, 6, 9; `remaining` 3→2→1 after each pulse; `done` in cycle 10; `busy` cycles 1–10.
- N=0, P=5 → no pulse; `done` and `busy` in cycle 1 only.
- N=4, P=0 → `out_pulse` high in cycles 1–4; `done` in cycle 5. Feeding this into a 4-step terminal-count counter yields exactly one wrap pulse.
- `start` re-pulsed with N=9 during a burst of N=2, P=1 → ignored: 2 pulses only. `reset` asserted in cycle 3 of a second burst → all outputs 0 immediately, no `done`.
- With `PULSE_BURST_ABORT_EN`: N=5, P=1, `abort` in cycle 4 → pulses in cycles 2 and 4 suppressed after cycle 2 (only cycle 2 pulse seen); IDLE in cycle 5; no `done`.
